// File: rtl/led_pwm_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite LED PWM controller.
package led_pwm_pkg;

  // Word index taken from address bits [4:2].
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_DUTY   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] PWM_PERIOD_M1 = 8'd254;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/led_pwm_gen.sv
// PWM counter, blink prescaler and blink phase; pure modulation, no bus logic.
module led_pwm_gen
  import led_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        blink_en,
  input  logic [7:0]  duty,
  input  logic [31:0] blink_div,
  input  logic        div_wr,
  output logic        pwm_on,
  output logic        blink_phase
);

  logic [7:0]  r_pwm_cnt;
  logic [31:0] r_presc;
  logic        r_phase;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else if (!enable) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == PWM_PERIOD_M1) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Prescaler is parked while blinking is off so a new blink always starts with a full lit half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_phase <= 1'b1;
    end else if (!blink_en) begin
      r_presc <= '0;
      r_phase <= 1'b1;
    end else if (div_wr) begin
      r_presc <= '0;
    end else if (r_presc == blink_div) begin
      r_presc <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  assign pwm_on      = (r_pwm_cnt < duty);
  assign blink_phase = r_phase;

endmodule

// File: rtl/axi_led_pwm_ctrl.sv
// AXI4-Lite slave with CTRL/LED_MASK/DUTY/BLINK_DIV/STATUS registers driving a registered LED bus.
module axi_led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int          C_S_AXI_ADDR_WIDTH = 12,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          LED_WIDTH          = 8,
  parameter logic [15:0] VERSION            = 16'h0100
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [LED_WIDTH-1:0]            led_o
);

  wr_state_t r_wr_state, w_wr_next;
  rd_state_t r_rd_state, w_rd_next;
  logic r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0] r_bresp, r_rresp;
  logic [31:0] r_rdata, w_rd_data;
  logic [1:0] r_ctrl;
  logic [LED_WIDTH-1:0] r_mask, r_led;
  logic [7:0] r_duty;
  logic [31:0] r_div;
  logic w_pwm_on, w_blink_phase, w_div_wr;

  // Byte-lane bits carry no meaning for a word-only register map.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  logic [2:0] w_aw_idx, w_ar_idx;
  logic       w_aw_ok, w_ar_ok, w_wr_fire, w_rd_fire;
  assign w_aw_idx  = s_axi_awaddr[4:2];
  assign w_ar_idx  = s_axi_araddr[4:2];
  assign w_aw_ok   = (s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:5] == '0) && (w_aw_idx <= REG_STATUS);
  assign w_ar_ok   = (s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:5] == '0) && (w_ar_idx <= REG_STATUS);
  assign w_wr_fire = r_awready & s_axi_awvalid & s_axi_wvalid;
  assign w_rd_fire = r_arready & s_axi_arvalid;
  assign w_div_wr  = w_wr_fire && w_aw_ok && (w_aw_idx == REG_DIV);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_wr_next = r_wr_state;
    unique case (r_wr_state)
      W_IDLE: if (w_wr_fire)    w_wr_next = W_RESP;
      W_RESP: if (s_axi_bready) w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_next = r_rd_state;
    unique case (r_rd_state)
      R_IDLE: if (w_rd_fire)    w_rd_next = R_DATA;
      R_DATA: if (s_axi_rready) w_rd_next = R_IDLE;
    endcase
  end

  // Ready is raised the cycle after both valids are seen, so it never depends combinationally on them.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_next;
      r_awready  <= (r_wr_state == W_IDLE) && !r_awready && s_axi_awvalid && s_axi_wvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ctrl <= '0;
      r_mask <= '0;
      r_duty <= 8'hFF;
      r_div  <= '0;
    end else if (w_wr_fire && w_aw_ok) begin
      unique case (w_aw_idx)
        REG_CTRL: if (s_axi_wstrb[0]) r_ctrl <= s_axi_wdata[1:0];
        REG_MASK: if (s_axi_wstrb[0]) r_mask <= s_axi_wdata[LED_WIDTH-1:0];
        REG_DUTY: if (s_axi_wstrb[0]) r_duty <= s_axi_wdata[7:0];
        REG_DIV: begin
          for (int b = 0; b < 4; b++) begin
            if (s_axi_wstrb[b]) r_div[8*b +: 8] <= s_axi_wdata[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_ar_ok) begin
      unique case (w_ar_idx)
        REG_CTRL: w_rd_data[1:0]           = r_ctrl;
        REG_MASK: w_rd_data[LED_WIDTH-1:0] = r_mask;
        REG_DUTY: w_rd_data[7:0]           = r_duty;
        REG_DIV:  w_rd_data                = r_div;
        REG_STATUS: begin
          w_rd_data[LED_WIDTH-1:0] = r_led;
          w_rd_data[8]             = w_blink_phase;
          w_rd_data[31:16]         = VERSION;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      r_arready  <= (r_rd_state == R_IDLE) && !r_arready && s_axi_arvalid;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  led_pwm_gen u_gen (
    .clk         (aclk),
    .rst_n       (aresetn),
    .enable      (r_ctrl[0]),
    .blink_en    (r_ctrl[1]),
    .duty        (r_duty),
    .blink_div   (r_div),
    .div_wr      (w_div_wr),
    .pwm_on      (w_pwm_on),
    .blink_phase (w_blink_phase)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_led <= '0;
    end else begin
      r_led <= r_ctrl[0] ? (r_mask & {LED_WIDTH{w_pwm_on & (r_ctrl[1] ? w_blink_phase : 1'b1)}}) : '0;
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_awready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign led_o         = r_led;

endmodule
